// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 256x8 registered-read memory between NREQ requesters.
// Independent round-robin arbiters for the write and read ports, registered
// memory controls, tagged 2-cycle read return with same-cycle write bypass.
// Optional burst lock is compiled in when MEM_ARB_LOCK_EN is defined.

module RrArbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_lock,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx
);
    logic [PW-1:0] r_ptr;
    logic          w_found;
    logic [PW-1:0] w_idx;
`ifdef MEM_ARB_LOCK_EN
    logic [PW-1:0] r_last;
    logic          r_last_vld;
    logic          w_hold;
`else
    logic          w_lock_unused;
    assign w_lock_unused = ^i_lock;
`endif

    // Winner is the first requester at or above the pointer, else the first below it; no grants while in reset
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
`ifdef MEM_ARB_LOCK_EN
        w_hold  = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i] && (i >= int'(r_ptr))) begin
                w_found = 1'b1;
                w_idx   = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i]) begin
                w_found = 1'b1;
                w_idx   = PW'(i);
            end
        end
`ifdef MEM_ARB_LOCK_EN
        if (r_last_vld && i_lock[r_last] && i_req[r_last]) begin
            w_found = 1'b1;
            w_idx   = r_last;
            w_hold  = 1'b1;
        end
`endif
        if (!reset) begin
            w_found = 1'b0;
        end
    end

    assign o_gnt = w_found ? (NREQ'(1) << w_idx) : '0;
    assign o_idx = w_idx;

    // Pointer moves just past the winner; a locked re-grant leaves it in place
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
`ifdef MEM_ARB_LOCK_EN
            r_last     <= '0;
            r_last_vld <= 1'b0;
`endif
        end else if (w_found) begin
`ifdef MEM_ARB_LOCK_EN
            r_last     <= w_idx;
            r_last_vld <= 1'b1;
            if (!w_hold) begin
                r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end
`else
            r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
`endif
        end
    end
endmodule

module mem_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    wr_req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]    wr_gnt,
    input  logic [NREQ-1:0]    rd_req,
    input  logic [NREQ*AW-1:0] rd_addr,
    output logic [NREQ-1:0]    rd_gnt,
    output logic [NREQ-1:0]    rd_valid,
    output logic [DW-1:0]      rd_data,
    input  logic [NREQ-1:0]    lock,
    output logic               mem_we,
    output logic [AW-1:0]      mem_wra,
    output logic [DW-1:0]      mem_wrd,
    output logic [AW-1:0]      mem_rda,
    input  logic [DW-1:0]      mem_rdd
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] w_wr_gnt;
    logic [NREQ-1:0] w_rd_gnt;
    logic [PW-1:0]   w_wr_idx;
    logic [PW-1:0]   w_rd_idx;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [AW-1:0]   w_wr_a;
    logic [DW-1:0]   w_wr_d;
    logic [AW-1:0]   w_rd_a;
    logic            w_hit;

    logic            r_mem_we;
    logic [AW-1:0]   r_mem_wra;
    logic [DW-1:0]   r_mem_wrd;
    logic [AW-1:0]   r_mem_rda;
    logic            r_vld1;
    logic [PW-1:0]   r_own1;
    logic            r_hit1;
    logic [DW-1:0]   r_byp1;
    logic            r_vld2;
    logic [PW-1:0]   r_own2;
    logic            r_hit2;
    logic [DW-1:0]   r_byp2;

    RrArbiter #(.NREQ(NREQ), .PW(PW)) u_wr_arb (
        .clock  (clock),
        .reset  (reset),
        .i_req  (wr_req),
        .i_lock (lock),
        .o_gnt  (w_wr_gnt),
        .o_idx  (w_wr_idx)
    );

    RrArbiter #(.NREQ(NREQ), .PW(PW)) u_rd_arb (
        .clock  (clock),
        .reset  (reset),
        .i_req  (rd_req),
        .i_lock (lock),
        .o_gnt  (w_rd_gnt),
        .o_idx  (w_rd_idx)
    );

    assign wr_gnt   = w_wr_gnt;
    assign rd_gnt   = w_rd_gnt;
    assign w_wr_acc = |(wr_req & w_wr_gnt);
    assign w_rd_acc = |(rd_req & w_rd_gnt);

    // Steer the granted requester's address and data onto the memory side
    always_comb begin
        w_wr_a = '0;
        w_wr_d = '0;
        w_rd_a = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_wr_gnt[i]) begin
                w_wr_a = wr_addr[i*AW +: AW];
                w_wr_d = wr_data[i*DW +: DW];
            end
            if (w_rd_gnt[i]) begin
                w_rd_a = rd_addr[i*AW +: AW];
            end
        end
    end

    assign w_hit = w_wr_acc && w_rd_acc && (w_wr_a == w_rd_a);

    // Write port: strobe for one cycle per accepted write, address/data hold otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_we  <= 1'b0;
            r_mem_wra <= '0;
            r_mem_wrd <= '0;
        end else begin
            r_mem_we <= w_wr_acc;
            if (w_wr_acc) begin
                r_mem_wra <= w_wr_a;
                r_mem_wrd <= w_wr_d;
            end
        end
    end

    // Read stage 1: drive the memory address and capture owner tag plus any colliding write data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_rda <= '0;
            r_vld1    <= 1'b0;
            r_own1    <= '0;
            r_hit1    <= 1'b0;
            r_byp1    <= '0;
        end else begin
            r_vld1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_mem_rda <= w_rd_a;
                r_own1    <= w_rd_idx;
                r_hit1    <= w_hit;
                r_byp1    <= w_wr_d;
            end
        end
    end

    // Read stage 2: tag travels alongside the memory's registered read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld2 <= 1'b0;
            r_own2 <= '0;
            r_hit2 <= 1'b0;
            r_byp2 <= '0;
        end else begin
            r_vld2 <= r_vld1;
            r_own2 <= r_own1;
            r_hit2 <= r_hit1;
            r_byp2 <= r_byp1;
        end
    end

    assign mem_we   = r_mem_we;
    assign mem_wra  = r_mem_wra;
    assign mem_wrd  = r_mem_wrd;
    assign mem_rda  = r_mem_rda;
    assign rd_valid = r_vld2 ? (NREQ'(1) << r_own2) : '0;
    assign rd_data  = r_vld2 ? (r_hit2 ? r_byp2 : mem_rdd) : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 256x8 registered-read memory.
// Read returns are checked by a scoreboard monitor; grants and memory controls directly.

module tb_mem_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 8;

    logic            clock;
    logic            reset;
    logic [NREQ-1:0] wr_req;
    logic [31:0]     wr_addr;
    logic [31:0]     wr_data;
    logic [NREQ-1:0] wr_gnt;
    logic [NREQ-1:0] rd_req;
    logic [31:0]     rd_addr;
    logic [NREQ-1:0] rd_gnt;
    logic [NREQ-1:0] rd_valid;
    logic [7:0]      rd_data;
    logic [NREQ-1:0] lock;
    logic            mem_we;
    logic [7:0]      mem_wra;
    logic [7:0]      mem_wrd;
    logic [7:0]      mem_rda;
    logic [7:0]      mem_rdd;

    int checks = 0;
    int errors = 0;

    logic [11:0] expQ[$];
    logic [11:0] monE;
    logic [7:0]  memArr[256];
    logic [3:0]  lockExp[5];

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_gnt   (wr_gnt),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .lock     (lock),
        .mem_we   (mem_we),
        .mem_wra  (mem_wra),
        .mem_wrd  (mem_wrd),
        .mem_rda  (mem_rda),
        .mem_rdd  (mem_rdd)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory model: write and registered read on the same edge, read returns the old contents
    initial begin
        for (int i = 0; i < 256; i++) memArr[i] = 8'h00;
        mem_rdd = 8'h00;
    end
    always @(posedge clock) begin
        if (mem_we) memArr[mem_wra] <= mem_wrd;
        mem_rdd <= memArr[mem_rda];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every read return must match the oldest expected entry
    always @(negedge clock) begin
        if (rd_valid !== 4'b0000) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_rd_valid: actual rd_valid %b rd_data %h, required no return", rd_valid, rd_data);
            end else begin
                monE = expQ.pop_front();
                if (rd_valid !== monE[11:8] || rd_data !== monE[7:0]) begin
                    errors++;
                    $display("[TB] FAIL read_return: actual rd_valid %b rd_data %h, required rd_valid %b rd_data %h",
                             rd_valid, rd_data, monE[11:8], monE[7:0]);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyWrite(input int i, input logic [7:0] a, input logic [7:0] d);
        wr_req[i]        = 1'b1;
        wr_addr[i*8 +: 8] = a;
        wr_data[i*8 +: 8] = d;
    endtask

    task automatic applyRead(input int i, input logic [7:0] a);
        rd_req[i]        = 1'b1;
        rd_addr[i*8 +: 8] = a;
    endtask

    task automatic applyStimulus(input logic [3:0] wrReq, input logic [3:0] rdReq, input logic [3:0] lk);
        wr_req = wrReq;
        rd_req = rdReq;
        lock   = lk;
    endtask

    task automatic checkGnt(input string name, input logic [3:0] expWr, input logic [3:0] expRd);
        @(negedge clock);
        checkOutput({name, "_wr_gnt"}, 32'(wr_gnt), 32'(expWr));
        checkOutput({name, "_rd_gnt"}, 32'(rd_gnt), 32'(expRd));
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic pushExp(input logic [3:0] own, input logic [7:0] data);
        expQ.push_back({own, data});
    endtask

    task automatic drainQueue(input string name);
        for (int k = 0; k < 10 && expQ.size() != 0; k++) begin
            @(negedge clock);
            #1;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
        nextCycle();
    endtask

    // Directed sequence with hand-tracked pointer values
    initial begin
        reset   = 1'b0;
        wr_req  = '0;
        rd_req  = '0;
        lock    = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
`ifdef MEM_ARB_LOCK_EN
        lockExp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
`else
        lockExp = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010};
`endif
        #1;
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        checkOutput("reset_mem_rda", 32'(mem_rda), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;

        // All four write for 8 cycles: strict rotation, memory strobe every cycle after the first
        for (int i = 0; i < 4; i++) applyWrite(i, 8'(32'h20 + i), 8'(32'h50 + i));
        for (int k = 0; k < 8; k++) begin
            checkGnt("rr_write", 4'(1 << (k % 4)), 4'b0000);
            if (k >= 1) begin
                checkOutput("rr_mem_we", 32'(mem_we), 32'd1);
                checkOutput("rr_mem_wra", 32'(mem_wra), 32'(8'(32'h20 + (k - 1) % 4)));
            end
            nextCycle();
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkGnt("rr_drop", 4'b0000, 4'b0000);
        checkOutput("rr_last_we", 32'(mem_we), 32'd1);
        checkOutput("rr_last_wra", 32'(mem_wra), 32'h23);
        nextCycle();
        checkGnt("idle", 4'b0000, 4'b0000);
        checkOutput("idle_mem_we", 32'(mem_we), 32'd0);
        checkOutput("idle_wra_hold", 32'(mem_wra), 32'h23);
        checkOutput("idle_wrd_hold", 32'(mem_wrd), 32'h53);
        nextCycle();

        // Same-cycle write and read of 0x10: read must see the new data
        applyWrite(2, 8'h10, 8'hA5);
        applyRead(1, 8'h10);
        checkGnt("bypass", 4'b0100, 4'b0010);
        pushExp(4'b0010, 8'hA5);
        nextCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkGnt("bypass_next", 4'b0000, 4'b0000);
        checkOutput("bypass_mem_we", 32'(mem_we), 32'd1);
        checkOutput("bypass_mem_wra", 32'(mem_wra), 32'h10);
        checkOutput("bypass_mem_wrd", 32'(mem_wrd), 32'hA5);
        checkOutput("bypass_mem_rda", 32'(mem_rda), 32'h10);
        nextCycle();

        // Write 0x3C to 0xFF, then back-to-back reads by requesters 3 and 0
        applyWrite(0, 8'hFF, 8'h3C);
        checkGnt("wr_ff", 4'b0001, 4'b0000);
        nextCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        applyRead(3, 8'hFF);
        checkGnt("rd_ff_r3", 4'b0000, 4'b1000);
        pushExp(4'b1000, 8'h3C);
        nextCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        applyRead(0, 8'hFF);
        checkGnt("rd_ff_r0", 4'b0000, 4'b0001);
        pushExp(4'b0001, 8'h3C);
        nextCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        // Two simultaneous readers: the loser keeps requesting and wins next cycle
        applyRead(1, 8'h22);
        applyRead(2, 8'h21);
        checkGnt("rd_pair_a", 4'b0000, 4'b0010);
        pushExp(4'b0010, 8'h52);
        nextCycle();
        rd_req[1] = 1'b0;
        checkGnt("rd_pair_b", 4'b0000, 4'b0100);
        pushExp(4'b0100, 8'h51);
        nextCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        // Lone requester 3, then the pointer wraps to 0 ahead of requester 2
        applyWrite(3, 8'h30, 8'h77);
        checkGnt("wrap_r3", 4'b1000, 4'b0000);
        nextCycle();
        wr_req[3] = 1'b0;
        applyWrite(0, 8'h31, 8'h66);
        applyWrite(2, 8'h32, 8'h55);
        checkGnt("wrap_r0", 4'b0001, 4'b0000);
        nextCycle();
        wr_req[0] = 1'b0;
        checkGnt("wrap_r2", 4'b0100, 4'b0000);
        nextCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkGnt("wrap_idle", 4'b0000, 4'b0000);
        checkOutput("wrap_mem_we", 32'(mem_we), 32'd1);
        checkOutput("wrap_mem_wra", 32'(mem_wra), 32'h32);
        nextCycle();
        checkGnt("wrap_idle2", 4'b0000, 4'b0000);
        checkOutput("wrap_mem_we_off", 32'(mem_we), 32'd0);
        checkOutput("wrap_wra_hold", 32'(mem_wra), 32'h32);
        nextCycle();
        applyRead(0, 8'h30);
        checkGnt("rd_wrap", 4'b0000, 4'b0001);
        pushExp(4'b0001, 8'h77);
        nextCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        applyRead(3, 8'h31);
        applyRead(2, 8'h32);
        checkGnt("rd_23_a", 4'b0000, 4'b0100);
        pushExp(4'b0100, 8'h55);
        nextCycle();
        rd_req[2] = 1'b0;
        checkGnt("rd_23_b", 4'b0000, 4'b1000);
        pushExp(4'b1000, 8'h66);
        nextCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        // Lock on requester 1 while 1 and 2 compete, then lock released
        applyWrite(1, 8'h40, 8'h11);
        applyWrite(2, 8'h41, 8'h22);
        lock = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) lock = 4'b0000;
            checkGnt("lock_seq", lockExp[k], 4'b0000);
            nextCycle();
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        drainQueue("drain_main");

        // Reset mid-burst: in-flight reads are dropped and outputs clear immediately
        for (int i = 0; i < 4; i++) applyRead(i, 8'(32'h20 + i));
        applyWrite(3, 8'h50, 8'h99);
        nextCycle();
        nextCycle();
        checkOutput("pre_reset_rd_valid", 32'(rd_valid), 32'b0001);
        checkOutput("pre_reset_rd_data", 32'(rd_data), 32'h50);
        checkOutput("pre_reset_mem_we", 32'(mem_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        checkOutput("async_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("async_rd_data", 32'(rd_data), 32'd0);
        checkOutput("async_mem_we", 32'(mem_we), 32'd0);
        checkOutput("async_mem_wra", 32'(mem_wra), 32'd0);
        checkOutput("async_mem_wrd", 32'(mem_wrd), 32'd0);
        checkOutput("async_mem_rda", 32'(mem_rda), 32'd0);
        checkOutput("async_wr_gnt", 32'(wr_gnt), 32'd0);
        checkOutput("async_rd_gnt", 32'(rd_gnt), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkGnt("post_reset_idle", 4'b0000, 4'b0000);
            checkOutput("post_reset_no_stale", 32'(rd_valid), 32'd0);
            nextCycle();
        end
        for (int i = 0; i < 4; i++) begin
            applyWrite(i, 8'(32'h60 + i), 8'(32'hC0 + i));
            applyRead(i, 8'hFF);
        end
        checkGnt("post_reset_first", 4'b0001, 4'b0001);
        pushExp(4'b0001, 8'h3C);
        nextCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        drainQueue("drain_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the 256 x 8 `memory` block (registered read, one write port, one read port) between NREQ requesters. Write and read ports are arbitrated independently, so one write and one read are accepted per cycle. The block registers the memory-side signals, returns read data with a tagged valid, and forwards same-cycle write data to a colliding read. It sits between the memory and the testers and other clients that currently drive the memory directly.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `AW`, 8, address width
- `DW`, 8, data width
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wr_req`  in  NREQ  write request, one bit per requester
- `wr_addr`  in  NREQ*AW  requester i at [i*AW +: AW]
- `wr_data`  in  NREQ*DW  requester i at [i*DW +: DW]
- `wr_gnt`  out  NREQ  one-hot, combinational; write accepted when wr_req[i] & wr_gnt[i]
- `rd_req`  in  NREQ  read request
- `rd_addr`  in  NREQ*AW  requester i at [i*AW +: AW]
- `rd_gnt`  out  NREQ  one-hot, combinational; read accepted when rd_req[i] & rd_gnt[i]
- `rd_valid`  out  NREQ  one-hot pulse marking the owner of rd_data
- `rd_data`  out  DW  read return data
- `lock`  in  NREQ  burst lock; present always, ignored unless MEM_ARB_LOCK_EN
- `mem_we`, `mem_wra`, `mem_wrd`, `mem_rda`  out  1/AW/DW/AW  registered memory controls
- `mem_rdd`  in  DW  memory read data

## Operation
- Two identical round-robin arbiters, write and read, each with a pointer `ptr` (0..NREQ-1), reset to 0.
- Grant: lowest index i >= ptr with req set, else wrap and search from 0. At most one grant per arbiter per cycle; no request means no grant.
- After a grant to i, `ptr <= (i+1) mod NREQ`. The pointer holds when there is no grant.
- Requesters hold req/addr/data stable until accepted. Dropping req before grant is legal.
- An accepted write registers mem_we=1, mem_wra, mem_wrd for the next cycle. With no write accepted, mem_we=0 and mem_wra/mem_wrd hold.
- An accepted read registers mem_rda and pipeline tag {valid, owner}. With no read accepted, mem_rda holds and the tag's valid bit is 0.
- Write-first semantics: if a read and a write to the same address are accepted in the same cycle, rd_data returns the new write data (bypass register). Otherwise rd_data = mem_rdd.
- Reset (asynchronous assert, any time): ptrs=0, mem_we=0, mem_wra=0, mem_wrd=0, mem_rda=0, rd_valid=0, tags and bypass cleared. In-flight reads are dropped, and no rd_valid is produced for them after reset releases.

## Timing
- Cycle N: req high -> gnt high in cycle N (same cycle, combinational from req and ptr).
- Cycle N+1: mem_* reflect the accepted transaction. The memory writes and samples the read at the end of N+1.
- Cycle N+2: rd_valid[i]=1 for one cycle with rd_data valid. Read latency is 2 cycles from acceptance.
- Fully pipelined: a new read can be accepted every cycle, and rd_valid may be high on consecutive cycles.
- A write accepted in cycle N is visible to a read accepted in cycle N (bypass) or later (memory).
- rd_valid and rd_data change only on clock edges or on reset assertion.

## Configuration
- `MEM_ARB_LOCK_EN` defined: if lock[i]=1, i was the last grantee of an arbiter, and req[i]=1, that arbiter grants i again regardless of ptr, and ptr does not advance. This allows atomic bursts. Lock is evaluated per arbiter.
- Undefined: lock is ignored and arbitration is pure round-robin.

## Test plan
- Reset: drive reset=0 mid-burst -> all outputs 0 immediately. After release, no stale rd_valid appears, and the first grant goes to requester 0 when all request.
- All four requesters hold wr_req for 8 cycles -> wr_gnt sequence 0,1,2,3,0,1,2,3, with mem_we=1 every cycle from cycle 1 on.
- Requester 2 writes 0xA5 to 0x10 and requester 1 reads 0x10 in the same cycle -> rd_valid[1] two cycles later with rd_data=0xA5 (bypass).
- Write 0x3C to 0xFF, then reads of 0xFF by requesters 3 then 0 on back-to-back cycles -> rd_valid 4'b1000 then 4'b0001 on consecutive cycles, both rd_data=0x3C.
- Only requester 3 requests, then requester 0 -> grant 3, then ptr wraps and grants 0. With no requests, mem_we=0 and mem_wra holds.
- With MEM_ARB_LOCK_EN, lock[1]=1 while requesters 1 and 2 both request for 4 cycles -> wr_gnt stays at 1 all four cycles, and 2 is granted on the first cycle after lock drops.
